ad_nios_adc_scheduler: RTL and testbench
========================================

# ad_nios_adc_scheduler

Sequences the board's external A/D converter and shares it between two requesters: the Nios CPU, which issues single-shot conversions, and a periodic round-robin channel scanner. It sits between the Nios-side register file and the ADC pins. It owns the start/busy/read handshake to the converter and returns every result, tagged with its channel, on one result strobe. It is clocked in the same domain as the other ad_nios logic.

## Interface
- NUM_CH, 8: channels scanned; channel field width is CH_W = clog2(NUM_CH).
- DATA_W, 12: ADC result width.
- BUSY_TO, 255: maximum cycles ad_busy may stay high before abort (used only with the timeout feature).
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- scan_en  in  1  enables the periodic scanner.
- scan_period  in  16  cycles between scan slots; 0 means back-to-back scanning.
- cpu_req  in  1  single-shot request; level, held until cpu_ack.
- cpu_ch  in  CH_W  channel for the CPU request; sampled at grant.
- cpu_ack  out  1  one-cycle pulse on completion of a CPU conversion.
- ad_start  out  1  one-cycle convert-start pulse to the ADC.
- ad_ch  out  CH_W  channel mux select; stable from START through READ.
- ad_busy  in  1  ADC converting; already synchronized upstream.
- ad_rd  out  1  one-cycle read strobe.
- ad_data  in  DATA_W  ADC parallel output; valid while ad_rd is high.
- res_valid  out  1  one-cycle result strobe.
- res_ch, res_data  out  CH_W, DATA_W  channel and data of the result; held until the next res_valid.
- res_cpu  out  1  result belongs to a CPU request.
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky abort flag.

## Operation
- Reset values: all outputs 0; state IDLE; scan channel pointer 0; period timer loaded with scan_period; scan_pending 0.
- Period timer:
  - Runs while scan_en=1 and counts down.
  - On reaching 0 it sets scan_pending and reloads scan_period.
  - With scan_period=0, scan_pending is set every cycle.
  - scan_en=0 clears scan_pending and holds the timer at its reload value.
- FSM states: IDLE → START → WAIT_BUSY → WAIT_DONE → READ → DONE → IDLE.
- IDLE arbitration:
  - cpu_req has fixed priority over scan_pending.
  - On grant, the channel (cpu_ch or the scan pointer) and the owner are latched.
  - A scan grant clears scan_pending.
- START: ad_start=1 for exactly one cycle.
- WAIT_BUSY: waits for ad_busy=1. If busy has not risen after 4 cycles, the FSM goes to the abort path.
- WAIT_DONE: waits for ad_busy=0.
- READ:
  - ad_rd=1 for one cycle.
  - ad_data is registered at the end of that cycle.
- DONE:
  - res_valid=1 with res_ch, res_data and res_cpu.
  - cpu_ack=1 if the owner is the CPU.
  - A scan owner increments the pointer, wrapping from NUM_CH-1 to 0.
- Abort path: DONE-equivalent cycle with res_valid=0 and cpu_ack=1 (if CPU-owned) so the CPU never hangs. timeout_err=1. The scan pointer still advances.
- A scan_pending that arrives while a conversion is in progress is remembered, not queued twice; at most one is pending.
- err_clr and a new timeout in the same cycle: set wins.
- reset_n asserted mid-conversion: all state is cleared immediately. No ad_rd is issued and no res_valid is produced.

## Timing
- Grant occurs in the IDLE cycle where a request is seen; ad_start follows in the next cycle.
- ADC busy for B cycles and rising one cycle after ad_start: res_valid comes B+4 cycles after ad_start.
- Turnaround: the FSM spends one IDLE cycle between DONE and the next START.
- cpu_ack coincides with res_valid. The CPU must drop cpu_req the cycle after cpu_ack, or it is re-granted.

## Configuration
- AD_SCHED_TIMEOUT_EN defined:
  - A busy-high watchdog counts cycles in WAIT_DONE.
  - When the count exceeds BUSY_TO, the FSM takes the abort path.
  - The 4-cycle busy-rise check is always present.
- Not defined: WAIT_DONE waits indefinitely and no watchdog counter is built.

## Test plan
- Reset, then scan_en=1, scan_period=0, ADC busy 10 cycles: results for ch 0,1,…,7,0 in order; res_valid spacing 15 cycles; res_cpu=0.
- scan_period=100 with scan_en=1: consecutive ad_start pulses exactly 100 cycles apart when the conversion time is below 100.
- cpu_req with cpu_ch=5 asserted in the same cycle as scan_pending: the CPU is granted first (ad_ch=5, res_cpu=1, cpu_ack); the scan conversion follows immediately; the scan pointer is unchanged by the CPU grant.
- ad_busy never rises: abort 4 cycles after ad_start; timeout_err=1; no res_valid; cpu_ack pulses; err_clr returns the flag to 0.
- With AD_SCHED_TIMEOUT_EN, ad_busy stuck high: abort after BUSY_TO+1 WAIT_DONE cycles and timeout_err=1. Without the macro: the FSM stays in WAIT_DONE.
- reset_n pulled low two cycles after ad_start: all outputs go to 0 asynchronously; after release, scanning restarts at ch 0.

Source files
------------

// File: rtl/ad_nios_adc_scheduler_if.sv
// ADC pin bundle between the scheduler (master) and the external converter (slave).
interface ad_nios_adc_scheduler_if #(
  parameter int unsigned CH_W   = 3,
  parameter int unsigned DATA_W = 12
);
  logic              start;
  logic [CH_W-1:0]   ch;
  logic              busy;
  logic              rd;
  logic [DATA_W-1:0] data;

  modport master (output start, ch, rd, input busy, data);
  modport slave  (input start, ch, rd, output busy, data);
endinterface

// File: rtl/ad_nios_adc_scheduler.sv
// Shares one external ADC between single-shot CPU requests and a periodic round-robin scanner.
// Define AD_SCHED_TIMEOUT_EN to build the busy-high watchdog in WAIT_DONE.
module ad_nios_adc_scheduler #(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned BUSY_TO = 255,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    scan_en,
  input  logic [15:0]             scan_period,
  input  logic                    cpu_req,
  input  logic [CH_W-1:0]         cpu_ch,
  output logic                    cpu_ack,
  ad_nios_adc_scheduler_if.master ad,
  output logic                    res_valid,
  output logic [CH_W-1:0]         res_ch,
  output logic [DATA_W-1:0]       res_data,
  output logic                    res_cpu,
  input  logic                    err_clr,
  output logic                    timeout_err
);

  typedef enum logic [2:0] {StIdle, StStart, StWaitBusy, StWaitDone, StRead, StDone} state_e;

  state_e            state_q;
  logic [CH_W-1:0]   ptr_q, ptr_nxt;
  logic              owner_cpu_q;
  logic [1:0]        rise_cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       timer_q, timer_cur, timer_dec;
  logic              armed_q;
  logic              scan_pending_q;
  logic              grant_cpu, grant_scan;

`ifdef AD_SCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(BUSY_TO + 1) + 1;
  logic [WdW-1:0] wd_q;
`endif

  // armed_q=0 means the timer sits at its reload value (after reset or while disabled).
  always_comb begin
    timer_cur = armed_q ? timer_q : scan_period;
    timer_dec = (timer_cur == 16'd0) ? 16'd0 : timer_cur - 16'd1;
    ptr_nxt   = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
    // No CPU grant in the ack cycle: the CPU gets one cycle to drop its request.
    grant_cpu  = (state_q == StIdle) && cpu_req && !cpu_ack;
    grant_scan = (state_q == StIdle) && !grant_cpu && scan_pending_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q        <= '0;
      armed_q        <= 1'b0;
      scan_pending_q <= 1'b0;
    end else if (!scan_en) begin
      timer_q        <= scan_period;
      armed_q        <= 1'b0;
      scan_pending_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (grant_scan) scan_pending_q <= 1'b0;
      if (timer_dec == 16'd0) begin
        scan_pending_q <= 1'b1;
        timer_q        <= scan_period;
      end else begin
        timer_q <= timer_dec;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_cpu_q <= 1'b0;
      rise_cnt_q  <= '0;
      data_q      <= '0;
      ad.start    <= 1'b0;
      ad.ch       <= '0;
      ad.rd       <= 1'b0;
      cpu_ack     <= 1'b0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_data    <= '0;
      res_cpu     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef AD_SCHED_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      ad.start  <= 1'b0;
      ad.rd     <= 1'b0;
      res_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      // A timeout set below overrides the clear.
      if (err_clr) timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_cpu) begin
            ad.ch       <= cpu_ch;
            owner_cpu_q <= 1'b1;
            ad.start    <= 1'b1;
            state_q     <= StStart;
          end else if (grant_scan) begin
            ad.ch       <= ptr_q;
            owner_cpu_q <= 1'b0;
            ad.start    <= 1'b1;
            state_q     <= StStart;
          end
        end
        StStart: begin
          rise_cnt_q <= '0;
`ifdef AD_SCHED_TIMEOUT_EN
          wd_q       <= '0;
`endif
          state_q    <= StWaitBusy;
        end
        StWaitBusy: begin
          if (ad.busy) begin
            state_q <= StWaitDone;
          end else if (rise_cnt_q == 2'd2) begin
            timeout_err <= 1'b1;
            cpu_ack     <= owner_cpu_q;
            if (!owner_cpu_q) ptr_q <= ptr_nxt;
            state_q     <= StIdle;
          end else begin
            rise_cnt_q <= rise_cnt_q + 2'd1;
          end
        end
        StWaitDone: begin
          if (!ad.busy) begin
            ad.rd   <= 1'b1;
            state_q <= StRead;
          end
`ifdef AD_SCHED_TIMEOUT_EN
          else if (wd_q == WdW'(BUSY_TO)) begin
            timeout_err <= 1'b1;
            cpu_ack     <= owner_cpu_q;
            if (!owner_cpu_q) ptr_q <= ptr_nxt;
            state_q     <= StIdle;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        StRead: begin
          data_q  <= ad.data;
          state_q <= StDone;
        end
        StDone: begin
          res_valid <= 1'b1;
          res_ch    <= ad.ch;
          res_data  <= data_q;
          res_cpu   <= owner_cpu_q;
          cpu_ack   <= owner_cpu_q;
          if (!owner_cpu_q) ptr_q <= ptr_nxt;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ad_nios_adc_scheduler.sv
// Directed bench for ad_nios_adc_scheduler with a behavioural ADC and an event log.
module tb_ad_nios_adc_scheduler;
  localparam int unsigned NUM_CH  = 8;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned BUSY_TO = 255;
  localparam int unsigned CH_W    = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              scan_en = 1'b0;
  logic [15:0]       scan_period = 16'd0;
  logic              cpu_req = 1'b0;
  logic [CH_W-1:0]   cpu_ch = '0;
  logic              cpu_ack;
  logic              res_valid;
  logic [CH_W-1:0]   res_ch;
  logic [DATA_W-1:0] res_data;
  logic              res_cpu;
  logic              err_clr = 1'b0;
  logic              timeout_err;

  int n_vec = 0;
  int n_err = 0;

  ad_nios_adc_scheduler_if #(.CH_W(CH_W), .DATA_W(DATA_W)) ad_if ();

  ad_nios_adc_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BUSY_TO(BUSY_TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .scan_en     (scan_en),
    .scan_period (scan_period),
    .cpu_req     (cpu_req),
    .cpu_ch      (cpu_ch),
    .cpu_ack     (cpu_ack),
    .ad          (ad_if),
    .res_valid   (res_valid),
    .res_ch      (res_ch),
    .res_data    (res_data),
    .res_cpu     (res_cpu),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // ADC model: mode 0 normal, 1 busy never rises, 2 busy stuck high.
  int adc_mode = 0;
  int busy_len = 10;
  int busy_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ad_if.busy <= 1'b0;
      busy_cnt   <= 0;
    end else if (ad_if.start && adc_mode != 1) begin
      ad_if.busy <= 1'b1;
      busy_cnt   <= busy_len;
    end else if (adc_mode != 2) begin
      if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
      else if (busy_cnt == 1) begin
        busy_cnt   <= 0;
        ad_if.busy <= 1'b0;
      end
    end
  end
  assign ad_if.data = 12'h300 + {9'd0, ad_if.ch} * 12'h011;

  int cyc = 0;
  int st_cyc[$], st_ch[$], rv_cyc[$], rv_ch[$], rv_data[$], ack_cyc[$];
  bit rv_cpu[$], rv_ack[$];
  int rd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ad_if.start) begin
      st_cyc.push_back(cyc);
      st_ch.push_back(int'(ad_if.ch));
    end
    if (res_valid) begin
      rv_cyc.push_back(cyc);
      rv_ch.push_back(int'(res_ch));
      rv_data.push_back(int'(res_data));
      rv_cpu.push_back(res_cpu);
      rv_ack.push_back(cpu_ack);
    end
    if (cpu_ack) ack_cyc.push_back(cyc);
    if (ad_if.rd) rd_cnt++;
  end

  task automatic clear_logs();
    st_cyc.delete(); st_ch.delete(); rv_cyc.delete(); rv_ch.delete();
    rv_data.delete(); rv_cpu.delete(); rv_ack.delete(); ack_cyc.delete();
    rd_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; scan_en = 1'b0; cpu_req = 1'b0; err_clr = 1'b0; adc_mode = 0;
    repeat (2) @(negedge clk);
    clear_logs();
    reset_n = 1'b1;
  endtask

  // Holds cpu_req until one cycle after cpu_ack, then drops it.
  task automatic run_cpu(input int budget);
    bit acked = 1'b0;
    for (int i = 0; i < budget && cpu_req; i++) begin
      @(negedge clk);
      if (acked) cpu_req = 1'b0;
      else if (cpu_ack) acked = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_vec++;
    if ({cpu_ack, res_valid, res_cpu, timeout_err, ad_if.start, ad_if.rd} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, want 000000",
               {cpu_ack, res_valid, res_cpu, timeout_err, ad_if.start, ad_if.rd});
    end
    n_vec++;
    if (ad_if.ch !== 3'd0 || res_ch !== 3'd0 || res_data !== 12'd0) begin
      n_err++;
      $display("FAIL reset_buses: ad_ch=%0d res_ch=%0d res_data=%h, want 0 0 000",
               ad_if.ch, res_ch, res_data);
    end
    repeat (2) @(negedge clk);
    clear_logs();
    reset_n = 1'b1;
  endtask

  task automatic test_scan_b2b();
    scan_period = 16'd0; busy_len = 10; scan_en = 1'b1;
    for (int i = 0; i < 400 && rv_cyc.size() < 9; i++) @(negedge clk);
    n_vec++;
    if (rv_cyc.size() < 9) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results, want 9", rv_cyc.size());
    end else begin
      for (int k = 0; k < 9; k++) begin
        n_vec++;
        if (rv_ch[k] !== k % 8 || rv_cpu[k] !== 1'b0 || rv_data[k] !== 'h300 + (k % 8) * 'h11)
        begin
          n_err++;
          $display("FAIL b2b_result[%0d]: ch=%0d cpu=%0d data=%h, want ch=%0d cpu=0 data=%h",
                   k, rv_ch[k], rv_cpu[k], rv_data[k], k % 8, 'h300 + (k % 8) * 'h11);
        end
        if (k > 0) begin
          n_vec++;
          if (rv_cyc[k] - rv_cyc[k-1] !== 15) begin
            n_err++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 15", k, rv_cyc[k] - rv_cyc[k-1]);
          end
        end
      end
    end
    scan_en = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_period();
    do_reset();
    scan_period = 16'd100; busy_len = 10; scan_en = 1'b1;
    for (int i = 0; i < 400 && st_cyc.size() < 3; i++) @(negedge clk);
    n_vec++;
    if (st_cyc.size() < 3) begin
      n_err++;
      $display("FAIL period_count: got %0d starts, want 3", st_cyc.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        n_vec++;
        if (st_cyc[k] - st_cyc[k-1] !== 100 || st_ch[k] !== k) begin
          n_err++;
          $display("FAIL period_gap[%0d]: gap=%0d ch=%0d, want gap=100 ch=%0d",
                   k, st_cyc[k] - st_cyc[k-1], st_ch[k], k);
        end
      end
    end
    scan_en = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_cpu_priority();
    bit acked = 1'b0;
    int exp_ch[3] = '{0, 5, 1};
    bit exp_cpu[3] = '{1'b0, 1'b1, 1'b0};
    do_reset();
    scan_period = 16'd0; busy_len = 10; scan_en = 1'b1;
    for (int i = 0; i < 20 && !ad_if.start; i++) @(negedge clk);
    cpu_ch = 3'd5; cpu_req = 1'b1;
    for (int i = 0; i < 200 && rv_cyc.size() < 3; i++) begin
      @(negedge clk);
      if (acked) cpu_req = 1'b0;
      else if (cpu_ack) acked = 1'b1;
    end
    cpu_req = 1'b0;
    n_vec++;
    if (rv_cyc.size() < 3 || st_cyc.size() < 3) begin
      n_err++;
      $display("FAIL prio_count: got %0d results %0d starts, want 3 3", rv_cyc.size(), st_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (rv_ch[k] !== exp_ch[k] || st_ch[k] !== exp_ch[k] || rv_cpu[k] !== exp_cpu[k] ||
            rv_ack[k] !== exp_cpu[k]) begin
          n_err++;
          $display("FAIL prio_result[%0d]: ch=%0d start_ch=%0d cpu=%0d ack=%0d, want ch=%0d cpu=ack=%0d",
                   k, rv_ch[k], st_ch[k], rv_cpu[k], rv_ack[k], exp_ch[k], exp_cpu[k]);
        end
      end
      n_vec++;
      if (st_cyc[2] - rv_cyc[1] !== 1 || ack_cyc.size() !== 1) begin
        n_err++;
        $display("FAIL prio_follow: scan start %0d cycles after ack, acks=%0d, want 1 and 1",
                 st_cyc[2] - rv_cyc[1], ack_cyc.size());
      end
    end
    scan_en = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_abort();
    do_reset();
    adc_mode = 1; cpu_ch = 3'd2; cpu_req = 1'b1;
    run_cpu(50);
    cpu_req = 1'b0;
    n_vec++;
    if (ack_cyc.size() !== 1 || st_cyc.size() < 1) begin
      n_err++;
      $display("FAIL abort_ack: acks=%0d starts=%0d, want 1 1", ack_cyc.size(), st_cyc.size());
    end else if (ack_cyc[0] - st_cyc[0] !== 4) begin
      n_err++;
      $display("FAIL abort_latency: got %0d cycles, want 4", ack_cyc[0] - st_cyc[0]);
    end
    n_vec++;
    if (timeout_err !== 1'b1 || rv_cyc.size() !== 0 || rd_cnt !== 0) begin
      n_err++;
      $display("FAIL abort_flags: err=%0d results=%0d rd=%0d, want 1 0 0",
               timeout_err, rv_cyc.size(), rd_cnt);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    n_vec++;
    if (timeout_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clr: got %0d, want 0", timeout_err);
    end
    // Scan conversion on ch0 aborts; pointer must still move on to ch1.
    scan_period = 16'd0; scan_en = 1'b1;
    for (int i = 0; i < 20 && !ad_if.start; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    adc_mode = 0;
    for (int i = 0; i < 60 && rv_cyc.size() < 1; i++) @(negedge clk);
    n_vec++;
    if (rv_cyc.size() < 1 || rv_ch[0] !== 1 || rv_cpu[0] !== 1'b0 || timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL abort_scan_advance: results=%0d ch=%0d err=%0d, want >=1 ch=1 err=1",
               rv_cyc.size(), rv_cyc.size() > 0 ? rv_ch[0] : -1, timeout_err);
    end
    scan_en = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_watchdog();
    do_reset();
    adc_mode = 2; cpu_ch = 3'd3; cpu_req = 1'b1;
`ifdef AD_SCHED_TIMEOUT_EN
    run_cpu(400);
    cpu_req = 1'b0;
    n_vec++;
    if (ack_cyc.size() !== 1 || st_cyc.size() < 1) begin
      n_err++;
      $display("FAIL wd_ack: acks=%0d starts=%0d, want 1 1", ack_cyc.size(), st_cyc.size());
    end else if (ack_cyc[0] - st_cyc[0] !== BUSY_TO + 3) begin
      n_err++;
      $display("FAIL wd_latency: got %0d cycles, want %0d", ack_cyc[0] - st_cyc[0], BUSY_TO + 3);
    end
    n_vec++;
    if (timeout_err !== 1'b1 || rv_cyc.size() !== 0) begin
      n_err++;
      $display("FAIL wd_flags: err=%0d results=%0d, want 1 0", timeout_err, rv_cyc.size());
    end
    adc_mode = 0;
`else
    repeat (300) @(negedge clk);
    n_vec++;
    if (ack_cyc.size() !== 0 || timeout_err !== 1'b0 || rv_cyc.size() !== 0) begin
      n_err++;
      $display("FAIL wd_absent: acks=%0d err=%0d results=%0d, want 0 0 0",
               ack_cyc.size(), timeout_err, rv_cyc.size());
    end
    adc_mode = 0;
    run_cpu(60);
    cpu_req = 1'b0;
    n_vec++;
    if (rv_cyc.size() !== 1 || rv_ch[0] !== 3 || rv_cpu[0] !== 1'b1 || rv_ack[0] !== 1'b1) begin
      n_err++;
      $display("FAIL wd_release: results=%0d ch=%0d cpu=%0d, want 1 3 1",
               rv_cyc.size(), rv_cyc.size() > 0 ? rv_ch[0] : -1,
               rv_cyc.size() > 0 ? int'(rv_cpu[0]) : -1);
    end
`endif
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int starts = 0;
    do_reset();
    scan_period = 16'd0; busy_len = 10; scan_en = 1'b1;
    for (int i = 0; i < 100 && starts < 3; i++) begin
      @(negedge clk);
      if (ad_if.start) starts++;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (ad_if.ch !== 3'd0 || res_ch !== 3'd0 || res_data !== 12'd0 || ad_if.start !== 1'b0 ||
        ad_if.rd !== 1'b0 || res_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: ad_ch=%0d res_ch=%0d res_data=%h start=%0d rd=%0d rv=%0d, want all 0",
               ad_if.ch, res_ch, res_data, ad_if.start, ad_if.rd, res_valid);
    end
    repeat (2) @(negedge clk);
    clear_logs();
    reset_n = 1'b1;
    for (int i = 0; i < 60 && rv_cyc.size() < 1; i++) @(negedge clk);
    n_vec++;
    if (rv_cyc.size() < 1 || rv_ch[0] !== 0) begin
      n_err++;
      $display("FAIL reset_restart: results=%0d ch=%0d, want >=1 ch=0",
               rv_cyc.size(), rv_cyc.size() > 0 ? rv_ch[0] : -1);
    end
    scan_en = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_scan_b2b();
    test_period();
    test_cpu_priority();
    test_abort();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
